centering_engine: RTL and testbench

Parametrised two-pass mean-removal engine for the whitening front end. Pass 1 streams a frame of 2^LOG2_N samples per channel and accumulates per-channel sums, then derives each mean with an arithmetic shift. Pass 2 re-streams the same frame and emits x - mean with valid/ready backpressure and saturation. It generalises the fixed 4-channel, 16-bit centering path to N_CH channels, DATA_W-bit data and a configurable frame length.

---
 rtl/centering_engine.sv | 168 ++++++++++++++++
 tb/tb_centering_engine.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/centering_engine.sv
// Two-pass per-channel mean removal: accumulate a frame, shift to mean,
// replay the frame and emit saturated x - mean. Option: CENTERING_ROUND_EN.
module centering_engine #(
  parameter int N_CH   = 4,
  parameter int DATA_W = 16,
  parameter int LOG2_N = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*DATA_W-1:0]   x_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH*DATA_W-1:0]   x_out,
  output logic [N_CH*DATA_W-1:0]   mean_out,
  output logic                     pass2,
  output logic                     busy,
  output logic                     done
);

  localparam int ACC_W = DATA_W + LOG2_N;
`ifdef CENTERING_ROUND_EN
  localparam int AW = ACC_W + 1;
  localparam logic signed [AW-1:0] RND =
    AW'(2 ** (LOG2_N - 1));
`else
  localparam int AW = ACC_W;
`endif
  localparam int CW = LOG2_N + 1;
  localparam logic [CW-1:0] LAST =
    CW'((1 << LOG2_N) - 1);
  localparam logic [CW-1:0] FULL =
    CW'(1 << LOG2_N);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    MEAN,
    SUB
  } state_t;

  state_t state, state_nx;

  logic signed [AW-1:0]     acc     [N_CH];
  logic signed [AW-1:0]     ext     [N_CH];
  logic signed [DATA_W-1:0] mean_nx [N_CH];
  logic signed [DATA_W:0]   diff    [N_CH];
  logic signed [DATA_W-1:0] sub_nx  [N_CH];
  logic [CW-1:0]            cnt;
  logic [CW-1:0]            ocnt;
  logic                     in_hs;
  logic                     out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Per-channel arithmetic: sign extension, mean, saturated difference
  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ext[k] = AW'($signed(x_in[k*DATA_W +: DATA_W]));
`ifdef CENTERING_ROUND_EN
      mean_nx[k] = DATA_W'((acc[k] + RND) >>> LOG2_N);
`else
      mean_nx[k] = DATA_W'(acc[k] >>> LOG2_N);
`endif
      diff[k] =
        (DATA_W+1)'($signed(x_in[k*DATA_W +: DATA_W])) -
        (DATA_W+1)'($signed(mean_out[k*DATA_W +: DATA_W]));
      if (diff[k][DATA_W] != diff[k][DATA_W-1]) begin
        if (diff[k][DATA_W])
          sub_nx[k] = {1'b1, {(DATA_W-1){1'b0}}};
        else
          sub_nx[k] = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        sub_nx[k] = diff[k][DATA_W-1:0];
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    pass2    = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nx = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_nx = MEAN;
      end
      MEAN: begin
        state_nx = SUB;
      end
      SUB: begin
        pass2    = 1'b1;
        in_ready = (out_ready | ~out_valid) & (cnt != FULL);
        if (out_hs && ocnt == LAST) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Accumulators, counters, mean and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_CH; k++) acc[k] <= '0;
      cnt       <= '0;
      ocnt      <= '0;
      mean_out  <= '0;
      x_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            for (int k = 0; k < N_CH; k++) acc[k] <= '0;
            cnt  <= '0;
            ocnt <= '0;
          end
        end
        ACCUM: begin
          if (in_hs) begin
            for (int k = 0; k < N_CH; k++)
              acc[k] <= acc[k] + ext[k];
            cnt <= cnt + 1'b1;
          end
        end
        MEAN: begin
          for (int k = 0; k < N_CH; k++)
            mean_out[k*DATA_W +: DATA_W] <= mean_nx[k];
          cnt  <= '0;
          ocnt <= '0;
        end
        SUB: begin
          if (in_hs) begin
            for (int k = 0; k < N_CH; k++)
              x_out[k*DATA_W +: DATA_W] <= sub_nx[k];
            cnt       <= cnt + 1'b1;
            out_valid <= 1'b1;
          end else if (out_hs) begin
            out_valid <= 1'b0;
          end
          if (out_hs) ocnt <= ocnt + 1'b1;
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_centering_engine.sv
// Directed bench: 4-ch LOG2_N=2 engine plus a 1-ch LOG2_N=1 engine.
// Expectations follow the build (floor or CENTERING_ROUND_EN).
module tb_centering_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 4-channel, 16-bit, N=4 instance
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] x_out;
  logic [63:0] mean_out;
  logic        pass2, busy, done;

  centering_engine #(.N_CH(4), .DATA_W(16), .LOG2_N(2)) dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
    .out_valid(out_valid), .out_ready(out_ready), .x_out(x_out),
    .mean_out(mean_out), .pass2(pass2), .busy(busy), .done(done)
  );

  // 1-channel, 16-bit, N=2 instance
  logic        go1 = 1'b0;
  logic        in_valid1 = 1'b0;
  logic        in_ready1;
  logic [15:0] x_in1 = '0;
  logic        out_valid1;
  logic [15:0] x_out1;
  logic [15:0] mean_out1;
  logic        pass2_1, busy1, done1;

  centering_engine #(.N_CH(1), .DATA_W(16), .LOG2_N(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .go(go1),
    .in_valid(in_valid1), .in_ready(in_ready1), .x_in(x_in1),
    .out_valid(out_valid1), .out_ready(1'b1), .x_out(x_out1),
    .mean_out(mean_out1), .pass2(pass2_1), .busy(busy1),
    .done(done1)
  );

  // Frame [sample][channel]
  int xa [4][4] = '{
    '{  4, -1, 1,  32767},
    '{  8, -2, 1,  32767},
    '{ 12, -2, 1, -32768},
    '{ 16, -2, 0, -32768}
  };
`ifdef CENTERING_ROUND_EN
  int mean_exp [4] = '{10, -2, 1, 0};
  int exp_tab [4][4] = '{
    '{ -6, 1,  0,  32767},
    '{ -2, 0,  0,  32767},
    '{  2, 0,  0, -32768},
    '{  6, 0, -1, -32768}
  };
`else
  int mean_exp [4] = '{10, -2, 0, -1};
  int exp_tab [4][4] = '{
    '{ -6, 1, 1,  32767},
    '{ -2, 0, 1,  32767},
    '{  2, 0, 1, -32767},
    '{  6, 0, 0, -32767}
  };
`endif

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lane(input logic [63:0] v, input int k);
    return int'($signed(v[k*16 +: 16]));
  endfunction

  function automatic logic [63:0] pack(input int i);
    logic [63:0] p;
    p = '0;
    if (i < 4)
      for (int k = 0; k < 4; k++) p[k*16 +: 16] = 16'(xa[i][k]);
    return p;
  endfunction

  task automatic run_big(input bit gaps, input bit bp,
                         input bit noise, input string nm);
    int  i;
    int  o;
    int  cyc;
    bit  replay;
    bit  hold;
    bit  edone;
    logic [63:0] held;
    i = 0; o = 0; cyc = 0; replay = 0; hold = 0; held = '0;
    @(negedge clk);
    go = 1'b1;
    while (o < 4 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      go = noise && (cyc % 3 == 0);
      if (pass2 && !replay) begin
        replay = 1;
        i = 0;
      end
      in_valid = (i < 4) && (!gaps || $urandom_range(0, 2) != 0);
      x_in = pack(i);
      out_ready = bp ? (cyc % 2 == 0) : 1'b1;
      #1;
      if (hold) chk({nm, "_hold"}, int'(x_out == held), 1);
      edone = out_valid && out_ready && o == 3;
      chk({nm, "_done"}, int'(done), int'(edone));
      if (out_valid && out_ready) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("%s_out%0d_ch%0d", nm, o, k),
              lane(x_out, k), exp_tab[o][k]);
        o++;
      end
      if (in_valid && in_ready) i++;
      hold = out_valid && !out_ready;
      held = x_out;
    end
    go = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk({nm, "_count"}, o, 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_mean_ch%0d", nm, k),
          lane(mean_out, k), mean_exp[k]);
    @(negedge clk);
    chk({nm, "_busy_end"}, int'(busy), 0);
    chk({nm, "_ov_end"}, int'(out_valid), 0);
  endtask

  task automatic run_small(input int a0, input int a1, input int m,
                           input int e0, input int e1,
                           input string nm);
    int i;
    int o;
    int cyc;
    bit replay;
    int xs [2];
    int es [2];
    xs[0] = a0; xs[1] = a1; es[0] = e0; es[1] = e1;
    i = 0; o = 0; cyc = 0; replay = 0;
    go1 = 1'b1;
    while (o < 2 && cyc < 50) begin
      @(negedge clk);
      cyc++;
      go1 = 1'b0;
      if (pass2_1 && !replay) begin
        replay = 1;
        i = 0;
      end
      in_valid1 = (i < 2);
      x_in1 = (i < 2) ? 16'(xs[i]) : '0;
      #1;
      chk({nm, "_done"}, int'(done1), int'(out_valid1 && o == 1));
      if (out_valid1) begin
        chk($sformatf("%s_out%0d", nm, o),
            int'($signed(x_out1)), es[o]);
        o++;
      end
      if (in_valid1 && in_ready1) i++;
    end
    in_valid1 = 1'b0;
    chk({nm, "_count"}, o, 2);
    chk({nm, "_mean"}, int'($signed(mean_out1)), m);
  endtask

  initial begin
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_x_out", int'(x_out == '0), 1);
    chk("rst_mean", int'(mean_out == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_big(1'b0, 1'b0, 1'b0, "plain");
    run_big(1'b1, 1'b1, 1'b1, "bp");

    // Abort pass 1 after two samples
    @(negedge clk);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    in_valid = 1'b1;
    x_in = pack(0);
    @(negedge clk);
    x_in = pack(1);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_pass2", int'(pass2), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_out_valid", int'(out_valid), 0);
    chk("abort_x_out", int'(x_out == '0), 1);
    chk("abort_mean", int'(mean_out == '0), 1);
    @(negedge clk);
    rst_n = 1'b1;

    run_big(1'b0, 1'b0, 1'b0, "fresh");

    // Single channel, back-to-back frames
    @(negedge clk);
    run_small(3, 5, 4, -1, 1, "n1a");
    @(negedge clk);
    chk("n1_idle_busy", int'(busy1), 0);
    run_small(10, 20, 15, -5, 5, "n1b");
    @(negedge clk);
    chk("n1_end_busy", int'(busy1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
